// File: rtl/frame_aligner.sv
// Word-level frame aligner: searches every bit offset of {in, prev} for SYNC, confirms the frame period, then emits aligned payload.
// Optional FRAME_ALIGNER_STATS_EN adds saturating slip_cnt / err_cnt outputs.
module frame_aligner #(
  parameter int             W         = 25,
  parameter logic [W-1:0]   SYNC      = {W{1'b0}} ^ 25'h1F35A0B,
  parameter int             FRAME_LEN = 8,
  parameter int             LOCK_CNT  = 3,
  parameter int             LOSS_CNT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [W-1:0]         in,
  output logic                 out_valid,
  output logic [W-1:0]         out,
  output logic                 out_sof,
  output logic                 locked,
  output logic [$clog2(W)-1:0] offset
`ifdef FRAME_ALIGNER_STATS_EN
  ,
  output logic [15:0]          slip_cnt,
  output logic [15:0]          err_cnt
`endif
);

  localparam int OW  = $clog2(W);
  localparam int WCW = $clog2(FRAME_LEN) + 1;
  localparam int HW  = $clog2(LOCK_CNT) + 1;
  localparam int MW  = $clog2(LOSS_CNT) + 1;

  localparam logic [WCW-1:0] WC_LAST  = WCW'(FRAME_LEN - 1);
  localparam logic [HW-1:0]  HITS_LIM = HW'(LOCK_CNT);
  localparam logic [MW-1:0]  MISS_LIM = MW'(LOSS_CNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t         state_q,      state_d;
  logic [W-1:0]   prev_q,       prev_d;
  logic           prev_vld_q,   prev_vld_d;
  logic [OW-1:0]  offset_q,     offset_d;
  logic [WCW-1:0] wc_q,         wc_d;
  logic [HW-1:0]  hits_q,       hits_d;
  logic [MW-1:0]  misses_q,     misses_d;
  logic           out_valid_q,  out_valid_d;
  logic           out_sof_q,    out_sof_d;
  logic [W-1:0]   out_q,        out_d;
  logic [15:0]    slip_q,       slip_d;
  logic [15:0]    err_q,        err_d;

  logic [2*W-1:0] window;
  logic           hunt_found;
  logic [OW-1:0]  hunt_k;
  logic [W-1:0]   cand;
  logic           cand_match;
  logic [WCW-1:0] wc_nxt;
  logic           at_sync;
  logic [HW-1:0]  hits_inc;
  logic [MW-1:0]  misses_inc;

  // Earlier bits of the serial stream sit in prev (low half of the window).
  always_comb begin
    window     = {in, prev_q};
    hunt_found = 1'b0;
    hunt_k     = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (window[k +: W] == SYNC) begin
        hunt_found = 1'b1;
        hunt_k     = OW'(k);
      end
    end
    cand       = window[offset_q +: W];
    cand_match = (cand == SYNC);
    wc_nxt     = (wc_q == WC_LAST) ? '0 : wc_q + 1'b1;
    at_sync    = (wc_nxt == '0);
    hits_inc   = hits_q + 1'b1;
    misses_inc = misses_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    offset_d    = offset_q;
    wc_d        = wc_q;
    hits_d      = hits_q;
    misses_d    = misses_q;
    out_valid_d = 1'b0;
    out_sof_d   = 1'b0;
    out_d       = out_q;
    slip_d      = slip_q;
    err_d       = err_q;

    if (in_valid) begin
      prev_d     = in;
      prev_vld_d = 1'b1;
      // The very first word after reset only primes prev.
      if (prev_vld_q) begin
        unique case (state_q)
          ST_HUNT: begin
            if (hunt_found) begin
              offset_d = hunt_k;
              wc_d     = '0;
              hits_d   = HW'(1);
              if (LOCK_CNT == 1) begin
                state_d  = ST_LOCKED;
                misses_d = '0;
              end else begin
                state_d  = ST_VERIFY;
              end
            end
          end

          ST_VERIFY: begin
            wc_d = wc_nxt;
            if (at_sync) begin
              if (cand_match) begin
                hits_d = hits_inc;
                if (hits_inc >= HITS_LIM) begin
                  state_d  = ST_LOCKED;
                  misses_d = '0;
                end
              end else begin
                state_d = ST_HUNT;
                hits_d  = '0;
              end
            end
          end

          ST_LOCKED: begin
            wc_d = wc_nxt;
            if (at_sync) begin
              if (cand_match) begin
                misses_d = '0;
              end else begin
                if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                if (misses_inc >= MISS_LIM) begin
                  misses_d = MISS_LIM;
                  hits_d   = '0;
                  state_d  = ST_HUNT;
                  if (slip_q != 16'hFFFF) slip_d = slip_q + 16'd1;
                end else begin
                  misses_d = misses_inc;
                end
              end
            end else begin
              out_valid_d = 1'b1;
              out_d       = cand;
              out_sof_d   = (wc_nxt == WCW'(1));
            end
          end

          default: state_d = ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      offset_q    <= '0;
      wc_q        <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_q       <= '0;
      slip_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      offset_q    <= offset_d;
      wc_q        <= wc_d;
      hits_q      <= hits_d;
      misses_q    <= misses_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_q       <= out_d;
      slip_q      <= slip_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out       = out_q;
  assign offset    = offset_q;
  assign locked    = (state_q == ST_LOCKED);

`ifdef FRAME_ALIGNER_STATS_EN
  assign slip_cnt = slip_q;
  assign err_cnt  = err_q;
`else
  logic stats_unused;
  assign stats_unused = ^{slip_q, err_q};
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// Directed bench for frame_aligner (W=8, SYNC=A5, FRAME_LEN=4, LOCK_CNT=3, LOSS_CNT=2).
// Inputs change #1 after posedge; outputs are sampled at that same point.
module tb_frame_aligner;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in;
  logic       out_valid;
  logic [7:0] out;
  logic       out_sof;
  logic       locked;
  logic [2:0] offset;
`ifdef FRAME_ALIGNER_STATS_EN
  logic [15:0] slip_cnt;
  logic [15:0] err_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int gap         = 0;
  logic [7:0] wds [4];

  always #5 clk = ~clk;

  frame_aligner #(
    .W(8), .SYNC(8'hA5), .FRAME_LEN(4), .LOCK_CNT(3), .LOSS_CNT(2)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in),
    .out_valid(out_valid), .out(out), .out_sof(out_sof),
    .locked(locked), .offset(offset)
`ifdef FRAME_ALIGNER_STATS_EN
    , .slip_cnt(slip_cnt), .err_cnt(err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted word, then `gap` idle cycles with junk on the data bus.
  task automatic send_chk(input logic [7:0] d, input logic ev, input logic [7:0] eo,
                          input logic es, input logic el);
    in_valid = 1'b1;
    in       = d;
    @(posedge clk); #1;
    chk("out_valid", 16'(out_valid), 16'(ev));
    chk("out_sof",   16'(out_sof),   16'(es));
    chk("locked",    16'(locked),    16'(el));
    if (ev) chk("out", 16'(out), 16'(eo));
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      in       = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk("gap_out_valid", 16'(out_valid), 16'h0);
      chk("gap_locked",    16'(locked),    16'(el));
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [7:0] d);
    rst      = 1'b1;
    in_valid = 1'b1;
    in       = d;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_sof",   16'(out_sof),   16'h0);
    chk("rst_locked",    16'(locked),    16'h0);
  endtask

  // Priming word plus three sync hits; lock appears on the tenth word.
  task automatic lock_seq();
    for (int i = 0; i < 10; i++)
      send_chk(wds[i % 4], 1'b0, 8'h00, 1'b0, (i == 9));
  endtask

  // Locked frame: payload 01,02,03 then the sync check word.
  task automatic frame(input logic [7:0] s0, input logic el);
    send_chk(wds[2], 1'b1, 8'h01, 1'b1, 1'b1);
    send_chk(wds[3], 1'b1, 8'h02, 1'b0, 1'b1);
    send_chk(s0,     1'b1, 8'h03, 1'b0, 1'b1);
    send_chk(wds[1], 1'b0, 8'h00, 1'b0, el);
  endtask

  task automatic quiet_frame(input logic [7:0] s0, input logic el);
    send_chk(wds[2], 1'b0, 8'h00, 1'b0, 1'b0);
    send_chk(wds[3], 1'b0, 8'h00, 1'b0, 1'b0);
    send_chk(s0,     1'b0, 8'h00, 1'b0, 1'b0);
    send_chk(wds[1], 1'b0, 8'h00, 1'b0, el);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 16'(out_valid), 16'h0);
    chk("reset_out_sof",   16'(out_sof),   16'h0);
    chk("reset_locked",    16'(locked),    16'h0);
    chk("reset_offset",    16'(offset),    16'h0);
    chk("reset_out",       16'(out),       16'h0);
    rst = 1'b0;

    // Aligned stream
    wds[0] = 8'hA5; wds[1] = 8'h01; wds[2] = 8'h02; wds[3] = 8'h03;
    lock_seq();
    chk("aligned_offset", 16'(offset), 16'h0);
    frame(8'hA5, 1'b1);

    // Single corrupted sync tolerated, then two in a row drop lock
    frame(8'hA4, 1'b1);
`ifdef FRAME_ALIGNER_STATS_EN
    chk("err_cnt_1",  err_cnt,  16'd1);
    chk("slip_cnt_0", slip_cnt, 16'd0);
`endif
    frame(8'hA5, 1'b1);
    frame(8'hA4, 1'b1);
    frame(8'hA4, 1'b0);
`ifdef FRAME_ALIGNER_STATS_EN
    chk("err_cnt_3",  err_cnt,  16'd3);
    chk("slip_cnt_1", slip_cnt, 16'd1);
`endif

    // VERIFY miss returns to HUNT: lock needs three fresh hits afterwards
    quiet_frame(8'hA5, 1'b0);
    quiet_frame(8'hA4, 1'b0);
    quiet_frame(8'hA5, 1'b0);
    quiet_frame(8'hA5, 1'b0);
    quiet_frame(8'hA5, 1'b1);
    frame(8'hA5, 1'b1);

    // Reset mid-frame while locked; in_valid during reset must be ignored
    send_chk(wds[2], 1'b1, 8'h01, 1'b1, 1'b1);
    do_reset(8'hA5);
    send_chk(wds[1], 1'b0, 8'h00, 1'b0, 1'b0);
    quiet_frame(8'hA5, 1'b0);
    quiet_frame(8'hA5, 1'b0);
    quiet_frame(8'hA5, 1'b1);
    frame(8'hA5, 1'b1);
`ifdef FRAME_ALIGNER_STATS_EN
    chk("err_cnt_after_rst",  err_cnt,  16'd0);
    chk("slip_cnt_after_rst", slip_cnt, 16'd0);
`endif

    // Stream shifted by 3 bits: A5 01 02 03 becomes 28 0D 10 18
    do_reset(8'h00);
    wds[0] = 8'h28; wds[1] = 8'h0D; wds[2] = 8'h10; wds[3] = 8'h18;
    lock_seq();
    chk("shift_offset", 16'(offset), 16'h3);
    frame(8'h28, 1'b1);
    do_reset(8'h00);
    chk("offset_cleared", 16'(offset), 16'h0);

    // in_valid toggling on an aligned stream
    wds[0] = 8'hA5; wds[1] = 8'h01; wds[2] = 8'h02; wds[3] = 8'h03;
    gap = 1;
    lock_seq();
    frame(8'hA5, 1'b1);
    gap = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
